instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- Front-end fetch stage of the CPU. Sits directly upstream of decode and drives the instruction memory port.
- Holds the PC and issues one word fetch at a time to a variable-latency instruction memory.
- Delivers {instruction, PC} to decode over a valid/ready handshake.
- Accepts branch redirects from downstream, which flush the stage.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, PC value after reset. Must be word aligned.
- COUNT_WIDTH, 16, width of the delivered-instruction counter.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IMemReq  out  1  one-cycle fetch request strobe.
- IMemAddr  out  ADDR_WIDTH  fetch address. Always equals PC.
- IMemValid  in  1  response strobe, one cycle, at least 1 cycle after IMemReq.
- IMemData  in  DATA_WIDTH  response word, valid with IMemValid.
- BranchTaken  in  1  redirect strobe from execute.
- BranchTarget  in  ADDR_WIDTH  redirect address; bits [1:0] are ignored and forced to 0.
- OutReady  in  1  decode can accept this cycle.
- OutValid  out  1  output slot holds an instruction.
- OutInstr  out  DATA_WIDTH  fetched instruction.
- OutPC  out  ADDR_WIDTH  address of OutInstr.
- FetchCount  out  COUNT_WIDTH  number of instructions accepted by decode.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State=BOOT, PC=RESET_PC, Discard=0.
  - IMemReq=0, OutValid=0, OutInstr=0, OutPC=0, FetchCount=0.
  - Reset mid-fetch abandons the request. A late IMemValid is ignored because the state is not WAIT.
- States:
  - BOOT: lasts one cycle after reset release, then go to ISSUE.
  - ISSUE:
    - If !OutValid or (OutValid and OutReady): IMemReq=1 for this cycle, go to WAIT.
    - Otherwise IMemReq=0 and stay in ISSUE.
  - WAIT:
    - IMemReq=0. The output slot is guaranteed empty here.
    - On IMemValid with Discard=0: OutInstr<=IMemData, OutPC<=PC, OutValid<=1, PC<=PC+4, go to ISSUE.
    - On IMemValid with Discard=1: drop the data, Discard<=0, go to ISSUE.
- Handshake:
  - A transfer occurs when OutValid and OutReady are both high; FetchCount increments by 1 and wraps.
  - With no transfer and no redirect, OutValid, OutInstr and OutPC hold stable.
  - Peak throughput is 1 instruction per 2 cycles; 1-cycle memory gives ISSUE/WAIT alternation.
- Redirect (BranchTaken=1) has priority over everything else:
  - PC<={BranchTarget[ADDR_WIDTH-1:2],2'b00}. OutValid<=0; any pending output is dropped and not counted.
  - A transfer in the same cycle still counts, since decode has already taken it.
  - In ISSUE with IMemReq=1 that cycle: Discard<=1, go to WAIT.
  - In ISSUE without a request: stay in ISSUE. The next request uses the target.
  - In WAIT without IMemValid: Discard<=1, stay in WAIT.
  - In WAIT with IMemValid in the same cycle: drop the data, go to ISSUE.
  - In BOOT: PC=target, go to ISSUE.
- Arithmetic: PC+4 wraps modulo 2^ADDR_WIDTH; 0xFFFFFFFC is followed by 0x00000000.
- At most one outstanding memory request at any time.

Test Plan:
- Reset release with RESET_PC=0, 1-cycle memory, OutReady=1:
  - IMemReq pulses on alternate cycles at addresses 0,4,8,12.
  - OutPC follows 0,4,8,12 with the matching data.
  - FetchCount=4 after 4 transfers.
- Backpressure:
  - Hold OutReady=0 for 5 cycles after the first word: OutValid stays 1, OutInstr/OutPC stable, no further IMemReq, FetchCount unchanged.
  - Raise OutReady: the transfer completes and the next request issues in the same cycle.
- Redirect while waiting on a 3-cycle memory:
  - BranchTaken with target 0x103 one cycle after the request.
  - The returned word is dropped (OutValid stays 0).
  - The next IMemAddr=0x100 and the delivered OutPC=0x100.
- Redirect coincident with IMemValid: the data is dropped, the next request goes to the target, OutValid=0 that cycle.
- Wrap: RESET_PC=0xFFFFFFFC. The first OutPC=0xFFFFFFFC and the second fetch address is 0x00000000.
- Async reset asserted mid-WAIT:
  - All outputs clear immediately without a clock edge.
  - A late IMemValid after release is ignored.
  - The fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: holds the PC, issues one word fetch at a time to a variable-latency
// instruction memory and hands {instruction, PC} to decode over valid/ready.
module instruction_fetch_stage #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           COUNT_WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic                   IMemReq,
  output logic [ADDR_WIDTH-1:0]  IMemAddr,
  input  logic                   IMemValid,
  input  logic [DATA_WIDTH-1:0]  IMemData,
  input  logic                   BranchTaken,
  input  logic [ADDR_WIDTH-1:0]  BranchTarget,
  input  logic                   OutReady,
  output logic                   OutValid,
  output logic [DATA_WIDTH-1:0]  OutInstr,
  output logic [ADDR_WIDTH-1:0]  OutPC,
  output logic [COUNT_WIDTH-1:0] FetchCount
);

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] S_BOOT  = 2'd0;
  localparam logic [STATE_W-1:0] S_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] S_WAIT  = 2'd2;

  logic [STATE_W-1:0]     state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   discard_q, discard_d;
  logic                   out_valid_d;
  logic [DATA_WIDTH-1:0]  out_instr_d;
  logic [ADDR_WIDTH-1:0]  out_pc_d;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   xfer;
  logic                   unused_target_lsb;

  assign IMemAddr          = pc_q;
  assign unused_target_lsb = &{1'b0, BranchTarget[1:0]};

  // State and datapath registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      OutValid   <= 1'b0;
      OutInstr   <= '0;
      OutPC      <= '0;
      FetchCount <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      OutValid   <= out_valid_d;
      OutInstr   <= out_instr_d;
      OutPC      <= out_pc_d;
      FetchCount <= count_d;
    end
  end

  // Next-state, request strobe and output slot update
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    out_valid_d = OutValid;
    out_instr_d = OutInstr;
    out_pc_d    = OutPC;
    count_d     = FetchCount;
    IMemReq     = 1'b0;
    xfer        = OutValid && OutReady;

    if (xfer) begin
      out_valid_d = 1'b0;
      count_d     = FetchCount + COUNT_WIDTH'(1);
    end

    case (state_q)
      S_BOOT: state_d = S_ISSUE;
      S_ISSUE: begin
        if (!OutValid || OutReady) begin
          IMemReq = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (IMemValid) begin
          state_d   = S_ISSUE;
          discard_d = 1'b0;
          if (!discard_q && !BranchTaken) begin
            out_instr_d = IMemData;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + ADDR_WIDTH'(4);
          end
        end
      end
      default: state_d = S_BOOT;
    endcase

    // A redirect overrides the PC and kills the slot; an in-flight fetch is marked stale
    if (BranchTaken) begin
      pc_d        = {BranchTarget[ADDR_WIDTH-1:2], 2'b00};
      out_valid_d = 1'b0;
      if ((state_q == S_ISSUE) && IMemReq) discard_d = 1'b1;
      if ((state_q == S_WAIT) && !IMemValid) discard_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: streaming, backpressure, redirects,
// PC wrap and asynchronous reset mid-fetch.
module tb_instruction_fetch_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemValid;
  logic [31:0] IMemData;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        OutReady;
  logic        OutValid;
  logic [31:0] OutInstr;
  logic [31:0] OutPC;
  logic [15:0] FetchCount;

  // Second instance starting just below the top of the address space
  logic        w_req, w_valid, w_out_valid;
  logic [31:0] w_addr, w_data, w_instr, w_pc;
  logic [15:0] w_count;

  int n_vec = 0;
  int n_err = 0;

  int unsigned mem_lat  = 1;
  bit          mem_auto = 1'b1;
  int unsigned mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  always #5 Clock = ~Clock;

  instruction_fetch_stage dut (
    .Clock(Clock), .Reset(Reset), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemValid(IMemValid), .IMemData(IMemData), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .OutReady(OutReady), .OutValid(OutValid),
    .OutInstr(OutInstr), .OutPC(OutPC), .FetchCount(FetchCount)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clock(Clock), .Reset(Reset), .IMemReq(w_req), .IMemAddr(w_addr),
    .IMemValid(w_valid), .IMemData(w_data), .BranchTaken(1'b0),
    .BranchTarget(32'h0), .OutReady(1'b1), .OutValid(w_out_valid),
    .OutInstr(w_instr), .OutPC(w_pc), .FetchCount(w_count)
  );

  // Fixed 1-cycle memory for the wrap instance
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      w_valid <= 1'b0;
      w_data  <= '0;
    end else begin
      w_valid <= w_req;
      w_data  <= w_addr ^ 32'hDEAD_0000;
    end
  end

  // Memory model: responds mem_lat cycles after a request, word = addr ^ DEAD0000
  always begin
    @(negedge Clock);
    if (mem_auto) begin
      IMemValid = 1'b0;
      if (mem_cnt != 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          IMemValid = 1'b1;
          IMemData  = mem_addr ^ 32'hDEAD_0000;
        end
      end
    end else begin
      mem_cnt = 0;
    end
    #4;
    if (mem_auto && IMemReq) begin
      mem_addr = IMemAddr;
      mem_cnt  = mem_lat;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic cyc();
    @(negedge Clock);
    #1;
  endtask

  initial begin
    Reset        = 1'b1;
    IMemValid    = 1'b0;
    IMemData     = '0;
    BranchTaken  = 1'b0;
    BranchTarget = '0;
    OutReady     = 1'b1;
    #1 Reset = 1'b0;

    cyc(); cyc(); #1;
    check_eq("rst_req",       IMemReq,    0);
    check_eq("rst_valid",     OutValid,   0);
    check_eq("rst_pc_out",    OutPC,      0);
    check_eq("rst_instr",     OutInstr,   0);
    check_eq("rst_count",     FetchCount, 0);
    check_eq("rst_addr",      IMemAddr,   0);
    check_eq("rst_wrap_addr", w_addr,     32'hFFFF_FFFC);

    // Boot cycle
    cyc(); Reset = 1'b1; #1;
    check_eq("boot_req", IMemReq, 0);

    // Streaming with 1-cycle memory: requests on alternate cycles
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      check_eq("str_req",  IMemReq,  1);
      check_eq("str_addr", IMemAddr, 32'(4 * k));
      if (k > 0) begin
        check_eq("str_valid", OutValid, 1);
        check_eq("str_pc",    OutPC,    32'(4 * (k - 1)));
        check_eq("str_instr", OutInstr, 32'hDEAD_0000 | 32'(4 * (k - 1)));
      end
      if (k == 1) begin
        check_eq("wrap_valid", w_out_valid, 1);
        check_eq("wrap_pc",    w_pc,        32'hFFFF_FFFC);
        check_eq("wrap_instr", w_instr,     32'h2152_FFFC);
        check_eq("wrap_req",   w_req,       1);
        check_eq("wrap_addr",  w_addr,      32'h0000_0000);
      end
      cyc(); #1;
      check_eq("str_idle", IMemReq, 0);
    end
    check_eq("str_count", FetchCount, 4);

    // Backpressure on word at 0x10
    OutReady = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cyc(); #1;
      check_eq("bp_valid", OutValid,   1);
      check_eq("bp_pc",    OutPC,      32'h10);
      check_eq("bp_instr", OutInstr,   32'hDEAD_0010);
      check_eq("bp_req",   IMemReq,    0);
      check_eq("bp_count", FetchCount, 4);
    end
    cyc(); OutReady = 1'b1; mem_lat = 3; #1;
    check_eq("bp_release_req",  IMemReq,  1);
    check_eq("bp_release_addr", IMemAddr, 32'h14);

    // Redirect one cycle after a request to a 3-cycle memory
    cyc(); BranchTaken = 1'b1; BranchTarget = 32'h103; #1;
    check_eq("rw_count", FetchCount, 5);
    check_eq("rw_req",   IMemReq,    0);
    cyc(); BranchTaken = 1'b0; #1;
    cyc(); #1;
    cyc(); #1;
    check_eq("rw_drop_valid", OutValid, 0);
    check_eq("rw_req_tgt",    IMemReq,  1);
    check_eq("rw_addr_tgt",   IMemAddr, 32'h100);
    cyc(); #1;
    cyc(); #1;
    cyc(); #1;
    check_eq("rw_wait_valid", OutValid, 0);
    cyc(); mem_lat = 1; #1;
    check_eq("rw_valid", OutValid, 1);
    check_eq("rw_pc",    OutPC,    32'h100);
    check_eq("rw_instr", OutInstr, 32'hDEAD_0100);
    check_eq("rw_next",  IMemAddr, 32'h104);

    // Redirect coincident with the memory response
    cyc(); BranchTaken = 1'b1; BranchTarget = 32'h200; #1;
    check_eq("rc_valid", OutValid,   0);
    check_eq("rc_count", FetchCount, 6);
    cyc(); BranchTaken = 1'b0; #1;
    check_eq("rc_drop_valid", OutValid, 0);
    check_eq("rc_req",        IMemReq,  1);
    check_eq("rc_addr",       IMemAddr, 32'h200);
    cyc(); #1;

    // Redirect while a stalled word is pending: dropped, not counted
    cyc(); OutReady = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h300; #1;
    check_eq("rp_valid", OutValid, 1);
    check_eq("rp_pc",    OutPC,    32'h200);
    check_eq("rp_instr", OutInstr, 32'hDEAD_0200);
    check_eq("rp_req",   IMemReq,  0);
    cyc(); BranchTaken = 1'b0; OutReady = 1'b1; mem_auto = 1'b0; #1;
    check_eq("rp_drop",  OutValid,   0);
    check_eq("rp_count", FetchCount, 6);
    check_eq("rp_req2",  IMemReq,    1);
    check_eq("rp_addr",  IMemAddr,   32'h300);

    // Asynchronous reset in the middle of WAIT
    cyc(); #1;
    Reset = 1'b0; #1;
    check_eq("ar_req",   IMemReq,    0);
    check_eq("ar_valid", OutValid,   0);
    check_eq("ar_pc",    OutPC,      0);
    check_eq("ar_instr", OutInstr,   0);
    check_eq("ar_count", FetchCount, 0);
    check_eq("ar_addr",  IMemAddr,   0);
    cyc(); Reset = 1'b1; IMemValid = 1'b1; IMemData = 32'hBAD0_BAD0; #1;
    check_eq("ar_boot_req", IMemReq, 0);
    cyc(); IMemValid = 1'b0; mem_auto = 1'b1; #1;
    check_eq("ar_late_valid", OutValid, 0);
    check_eq("ar_restart_req",  IMemReq,  1);
    check_eq("ar_restart_addr", IMemAddr, 0);
    cyc(); #1;
    cyc(); #1;
    check_eq("ar_out_valid", OutValid, 1);
    check_eq("ar_out_pc",    OutPC,    0);
    check_eq("ar_out_instr", OutInstr, 32'hDEAD_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
